// File: rtl/aes_byte_state_sequencer_if.sv
// Byte-pair handshake bundle between the AES state/key source, the
// byte-state sequencer and the masked AddRoundKey byte slice.
// slave  : sequencer side
// master : driver / upstream-downstream side
interface aes_byte_state_sequencer_if #(
  parameter int IDXW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_state;
  logic [7:0]      in_key;
  logic            in_mask1;
  logic            in_mask2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_state;
  logic [7:0]      out_key;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            mask1;
  logic            mask2;
  logic            busy;

  modport slave (
    input  in_valid, in_state, in_key, in_mask1, in_mask2, flush, out_ready,
    output in_ready, out_valid, out_state, out_key, out_idx, out_last,
           mask1, mask2, busy
  );

  modport master (
    output in_valid, in_state, in_key, in_mask1, in_mask2, flush, out_ready,
    input  in_ready, out_valid, out_state, out_key, out_idx, out_last,
           mask1, mask2, busy
  );
endinterface

// File: rtl/aes_byte_state_sequencer.sv
// Byte-serial buffer feeding the masked AddRoundKey byte slice.
// Loads one NBYTES-byte state block plus its round-key bytes, then replays
// them one pair per cycle with the block masks held constant.
// Optional macro AES_SEQ_STORE_MASKED_EN: state bytes are stored (and
// emitted) already XORed with the block's mask1 replicated over 8 bits.
//
// state  | meaning
// LOAD   | accepting byte pairs into mem[wr_cnt]; outputs idle
// STREAM | presenting mem[rd_cnt] downstream; input closed
module aes_byte_state_sequencer #(
  parameter int NBYTES = 16,
  parameter int IDXW   = 4
) (
  input logic                       clk,
  input logic                       rst,
  aes_byte_state_sequencer_if.slave bus
);
  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
  localparam logic [IDXW-1:0] ONE      = IDXW'(1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] wr_cnt_q, wr_cnt_d;
  logic [IDXW-1:0] rd_cnt_q, rd_cnt_d;
  logic            mask1_q, mask1_d;
  logic            mask2_q, mask2_d;
  logic            wr_en;
  logic [15:0]     wr_data;
  logic [15:0]     mem [NBYTES];
  logic            streaming;

  // Next-state, counter and mask update; flush wins over any handshake.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    mask1_d  = mask1_q;
    mask2_d  = mask2_q;
    wr_en    = 1'b0;
    wr_data  = {bus.in_state, bus.in_key};
    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == '0) begin
            mask1_d = bus.in_mask1;
            mask2_d = bus.in_mask2;
          end
`ifdef AES_SEQ_STORE_MASKED_EN
          // mask1_d is the live input on byte 0, the latched mask otherwise
          wr_data[15:8] = bus.in_state ^ {8{mask1_d}};
`endif
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            state_d  = STREAM;
          end else begin
            wr_cnt_d = wr_cnt_q + ONE;
          end
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d = '0;
            state_d  = LOAD;
          end else begin
            rd_cnt_d = rd_cnt_q + ONE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    if (bus.flush) begin
      state_d  = LOAD;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      mask1_d  = mask1_q;
      mask2_d  = mask2_q;
      wr_en    = 1'b0;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      mask1_q  <= 1'b0;
      mask2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      mask1_q  <= mask1_d;
      mask2_q  <= mask2_d;
    end
  end

  // Byte-pair storage; contents are never cleared, only gated on output.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_cnt_q] <= wr_data;
    end
  end

  assign streaming     = (state_q == STREAM);
  assign bus.in_ready  = !streaming;
  assign bus.out_valid = streaming;
  assign bus.out_state = streaming ? mem[rd_cnt_q][15:8] : 8'h00;
  assign bus.out_key   = streaming ? mem[rd_cnt_q][7:0]  : 8'h00;
  assign bus.out_idx   = streaming ? rd_cnt_q : '0;
  assign bus.out_last  = streaming && (rd_cnt_q == LAST_IDX);
  assign bus.mask1     = mask1_q;
  assign bus.mask2     = mask2_q;
  assign bus.busy      = streaming || (wr_cnt_q != '0);
endmodule
